// File: rtl/iir_inv.sv
// iir_inv: inverse of the 3-tap IIR (b = 2,4,8; feedback >>1, >>2).
// Recovers 8-bit x[n] from 16-bit y[n] in a two-stage valid/ready pipe.
// Ports: clk, rst (async, active-low), clr (sync history clear),
//   in_valid/in_ready/y_in (input stream),
//   out_valid/out_ready/x_out/err (output stream),
//   err_cnt (saturating error count, only with IIR_INV_ERRCNT_EN).
module iir_inv (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] y_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  x_out,
    output logic        err
`ifdef IIR_INV_ERRCNT_EN
    ,
    output logic [7:0]  err_cnt
`endif
);

    logic [15:0] w1_q, w1_d;
    logic [15:0] w2_q, w2_d;
    logic [15:0] s1_w_q, s1_w_d;
    logic        s1_v_q, s1_v_d;
    logic [7:0]  x1_q, x1_d;
    logic [7:0]  x2_q, x2_d;
    logic [7:0]  s2_x_q, s2_x_d;
    logic        s2_bad_q, s2_bad_d;
    logic        s2_v_q, s2_v_d;
`ifdef IIR_INV_ERRCNT_EN
    logic [7:0]  err_cnt_q, err_cnt_d;
`endif

    logic        acc;
    logic        mv;
    logic        pop;
    logic [15:0] w_new;
    logic [15:0] d;

    assign pop      = s2_v_q && out_ready;
    assign mv       = s1_v_q && (!s2_v_q || out_ready);
    assign in_ready = !clr && (!s1_v_q || !s2_v_q || out_ready);
    assign acc      = in_valid && in_ready;

    // Undo the feedback recursion (logical shifts on the w history).
    assign w_new = y_in + {1'b0, w1_q[15:1]} + {2'b0, w2_q[15:2]};

    // Undo the FIR part; a valid x leaves d = 2x with d[15:9] clear.
    assign d = s1_w_q - {6'b0, x1_q, 2'b0} - {5'b0, x2_q, 3'b0};

    always_comb begin
        w1_d     = w1_q;
        w2_d     = w2_q;
        s1_w_d   = s1_w_q;
        s1_v_d   = s1_v_q;
        x1_d     = x1_q;
        x2_d     = x2_q;
        s2_x_d   = s2_x_q;
        s2_bad_d = s2_bad_q;
        s2_v_d   = s2_v_q;
`ifdef IIR_INV_ERRCNT_EN
        err_cnt_d = err_cnt_q;
`endif
        if (clr) begin
            w1_d   = '0;
            w2_d   = '0;
            x1_d   = '0;
            x2_d   = '0;
            s1_v_d = 1'b0;
            s2_v_d = 1'b0;
`ifdef IIR_INV_ERRCNT_EN
            err_cnt_d = '0;
`endif
        end else begin
            if (acc) begin
                w2_d   = w1_q;
                w1_d   = w_new;
                s1_w_d = w_new;
                s1_v_d = 1'b1;
            end else if (mv) begin
                s1_v_d = 1'b0;
            end
            // Bad samples still feed x history; only clr resyncs.
            if (mv) begin
                x2_d     = x1_q;
                x1_d     = d[8:1];
                s2_x_d   = d[8:1];
                s2_bad_d = d[0] | (d[15:9] != 7'd0);
                s2_v_d   = 1'b1;
            end else if (pop) begin
                s2_v_d = 1'b0;
            end
`ifdef IIR_INV_ERRCNT_EN
            if (pop && s2_bad_q && err_cnt_q != 8'hFF)
                err_cnt_d = err_cnt_q + 8'd1;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w1_q     <= '0;
            w2_q     <= '0;
            s1_w_q   <= '0;
            s1_v_q   <= 1'b0;
            x1_q     <= '0;
            x2_q     <= '0;
            s2_x_q   <= '0;
            s2_bad_q <= 1'b0;
            s2_v_q   <= 1'b0;
`ifdef IIR_INV_ERRCNT_EN
            err_cnt_q <= '0;
`endif
        end else begin
            w1_q     <= w1_d;
            w2_q     <= w2_d;
            s1_w_q   <= s1_w_d;
            s1_v_q   <= s1_v_d;
            x1_q     <= x1_d;
            x2_q     <= x2_d;
            s2_x_q   <= s2_x_d;
            s2_bad_q <= s2_bad_d;
            s2_v_q   <= s2_v_d;
`ifdef IIR_INV_ERRCNT_EN
            err_cnt_q <= err_cnt_d;
`endif
        end
    end

    assign out_valid = s2_v_q;
    assign x_out     = s2_x_q;
    assign err       = s2_bad_q;
`ifdef IIR_INV_ERRCNT_EN
    assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_iir_inv.sv
// tb_iir_inv: directed table vectors plus multi-cycle sequences
// and a forward-IIR round trip for iir_inv.
module tb_iir_inv;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] y_in;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  x_out;
    logic        err;
`ifdef IIR_INV_ERRCNT_EN
    logic [7:0]  err_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] y;
        logic [7:0]  x;
        logic        e;
    } vec_t;

    localparam int NV = 6;
    vec_t tv [NV];

    iir_inv dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y_in      (y_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_out     (x_out),
        .err       (err)
`ifdef IIR_INV_ERRCNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h",
                     nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("clr_in_ready", {31'd0, in_ready}, 0);
        tick();
        clr = 1'b0;
    endtask

    // Impulse table, back-to-back, out_ready held high.
    task automatic run_table(input string tag);
        out_ready = 1'b1;
        for (int k = 0; k < NV + 2; k++) begin
            in_valid = (k < NV);
            y_in = (k < NV) ? tv[k].y : 16'h0;
            #1;
            if (k < 2) begin
                chk({tag, "_lat_ov"}, {31'd0, out_valid}, 0);
            end else begin
                chk({tag, "_ov"}, {31'd0, out_valid}, 1);
                chk({tag, "_x"}, {24'd0, x_out},
                    {24'd0, tv[k-2].x});
                chk({tag, "_err"}, {31'd0, err},
                    {31'd0, tv[k-2].e});
            end
            if (k < NV)
                chk({tag, "_ir"}, {31'd0, in_ready}, 1);
            tick();
        end
        in_valid = 1'b0;
    endtask

    // Single sample with out_ready high; check at the output.
    task automatic one(input string nm, input logic [15:0] y,
                       input logic [7:0] ex, input logic ee);
        out_ready = 1'b1;
        in_valid = 1'b1;
        y_in = y;
        tick();
        in_valid = 1'b0;
        tick();
        chk({nm, "_ov"}, {31'd0, out_valid}, 1);
        chk({nm, "_x"}, {24'd0, x_out}, {24'd0, ex});
        chk({nm, "_err"}, {31'd0, err}, {31'd0, ee});
        tick();
    endtask

    logic [7:0]  xs [1000];
    logic [7:0]  q [$];
    logic [7:0]  xh1, xh2, xc, ex;
    logic [15:0] wh1, wh2, wc;
    int sent, got;

    initial begin
        tv[0] = '{16'h0002, 8'd1, 1'b0};
        tv[1] = '{16'h0003, 8'd0, 1'b0};
        tv[2] = '{16'h0006, 8'd0, 1'b0};
        tv[3] = '{16'hFFFB, 8'd0, 1'b0};
        tv[4] = '{16'hFFFE, 8'd0, 1'b0};
        tv[5] = '{16'h0000, 8'd0, 1'b0};

        rst = 1'b0;
        clr = 1'b0;
        in_valid = 1'b0;
        y_in = '0;
        out_ready = 1'b0;
        #3;
        chk("rst_in_ready", {31'd0, in_ready}, 1);
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_x_out", {24'd0, x_out}, 0);
        chk("rst_err", {31'd0, err}, 0);
`ifdef IIR_INV_ERRCNT_EN
        chk("rst_err_cnt", {24'd0, err_cnt}, 0);
`endif
        tick();
        rst = 1'b1;
        tick();

        run_table("imp");

        // Error detection.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        one("e_odd", 16'h0001, 8'h00, 1'b1);
`ifdef IIR_INV_ERRCNT_EN
        chk("ecnt_1", {24'd0, err_cnt}, 1);
`endif
        do_clr();
`ifdef IIR_INV_ERRCNT_EN
        chk("ecnt_clr", {24'd0, err_cnt}, 0);
`endif
        one("e_big", 16'h0200, 8'h00, 1'b1);
        // w = 1 + 0x200>>1 = 0x101: odd d.
        one("e_odd2", 16'h0001, 8'h80, 1'b1);
`ifdef IIR_INV_ERRCNT_EN
        chk("ecnt_2", {24'd0, err_cnt}, 2);
`endif

        // Backpressure: 3 offered, 2 accepted.
        do_clr();
        out_ready = 1'b0;
        in_valid = 1'b1;
        y_in = 16'h0002;
        #1;
        chk("bp_ir0", {31'd0, in_ready}, 1);
        tick();
        y_in = 16'h0003;
        #1;
        chk("bp_ir1", {31'd0, in_ready}, 1);
        tick();
        y_in = 16'h0006;
        #1;
        chk("bp_ir2", {31'd0, in_ready}, 0);
        chk("bp_ov", {31'd0, out_valid}, 1);
        tick();
        chk("bp_hold_x", {24'd0, x_out}, 1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("bp_d0_ov", {31'd0, out_valid}, 1);
        chk("bp_d0_x", {24'd0, x_out}, 1);
        tick();
        chk("bp_d1_ov", {31'd0, out_valid}, 1);
        chk("bp_d1_x", {24'd0, x_out}, 0);
        chk("bp_d1_err", {31'd0, err}, 0);
        tick();
        chk("bp_d2_ov", {31'd0, out_valid}, 0);

        // clr with both stages full.
        out_ready = 1'b0;
        in_valid = 1'b1;
        y_in = 16'h1234;
        tick();
        y_in = 16'h0777;
        tick();
        chk("cm_full_ir", {31'd0, in_ready}, 0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("cm_ov", {31'd0, out_valid}, 0);
        chk("cm_ir", {31'd0, in_ready}, 1);
        run_table("cm");

        // Async reset mid-burst.
        out_ready = 1'b1;
        in_valid = 1'b1;
        y_in = 16'h0002;
        tick();
        y_in = 16'h0003;
        tick();
        chk("ar_pre_ov", {31'd0, out_valid}, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_ov", {31'd0, out_valid}, 0);
        chk("ar_x", {24'd0, x_out}, 0);
        chk("ar_err", {31'd0, err}, 0);
        chk("ar_ir", {31'd0, in_ready}, 1);
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        run_table("ar");

        // Round trip through a forward-IIR model.
        do_clr();
        foreach (xs[i]) xs[i] = 8'($urandom_range(0, 255));
        xh1 = 0; xh2 = 0; wh1 = 0; wh2 = 0;
        sent = 0; got = 0;
        for (int cyc = 0; cyc < 8000 && got < 1000; cyc++) begin
            in_valid = (sent < 1000) &&
                       ($urandom_range(0, 3) != 0);
            xc = (sent < 1000) ? xs[sent] : 8'd0;
            wc = {7'd0, xc, 1'b0} + {6'd0, xh1, 2'b0}
               + {5'd0, xh2, 3'b0};
            y_in = wc - {1'b0, wh1[15:1]} - {2'b0, wh2[15:2]};
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("rt_spurious", 1, 0);
                end else begin
                    ex = q.pop_front();
                    chk("rt_x", {24'd0, x_out}, {24'd0, ex});
                    chk("rt_err", {31'd0, err}, 0);
                end
                got++;
            end
            if (in_valid && in_ready) begin
                q.push_back(xc);
                xh2 = xh1; xh1 = xc;
                wh2 = wh1; wh1 = wc;
                sent++;
            end
            tick();
        end
        in_valid = 1'b0;
        chk("rt_count", got, 1000);
        chk("rt_left", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
